// File: rtl/dequant_pkg.sv
// Shared widths, state encoding, zigzag map and saturation helper for the
// MJPEG dequantization stage.
package dequant_pkg;

   localparam int unsigned COEF_W   = 12;
   localparam int unsigned Q_W      = 8;
   localparam int unsigned OUT_W    = 16;
   localparam int unsigned PROD_W   = COEF_W + Q_W + 1;
   localparam int unsigned K_W      = 6;
   localparam int unsigned NUM_COEF = 64;

   localparam int OUT_MAX = (2 ** (OUT_W - 1)) - 1;
   localparam int OUT_MIN = -(2 ** (OUT_W - 1));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FILL = 2'd2
   } state_e;

   // Zigzag scan index -> natural (row*8+col) address.
   localparam logic [K_W-1:0] ZZ [NUM_COEF] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [PROD_W-1:0] p);
      if (p > PROD_W'(OUT_MAX))      return OUT_W'(OUT_MAX);
      else if (p < PROD_W'(OUT_MIN)) return OUT_W'(OUT_MIN);
      else                           return OUT_W'(p);
   endfunction

endpackage

// File: rtl/dequant_qtab.sv
// Luma/chroma quantization tables: one write port, one asynchronous read port,
// every entry resets to 1 so an unprogrammed table is the identity.
module dequant_qtab
   import dequant_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  logic           wr_sel,
   input  logic [K_W-1:0] wr_addr,
   input  logic [Q_W-1:0] wr_data,
   input  logic           rd_sel,
   input  logic [K_W-1:0] rd_addr,
   output logic [Q_W-1:0] rd_data_c
);

   logic [Q_W-1:0] mem_q [2][NUM_COEF];
   logic [Q_W-1:0] mem_d [2][NUM_COEF];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_sel][wr_addr] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < NUM_COEF; i++) begin
               mem_q[t][i] <= Q_W'(1);
            end
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
   assign rd_data_c = mem_q[rd_sel][rd_addr];

endmodule

// File: rtl/dequant_ctrl.sv
// Dequantization sequencer: multiplies zigzag coefficients by the selected
// table, emits natural-order addresses and zero-fills after end-of-block.
module dequant_ctrl
   import dequant_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     qt_wr_en,
   input  logic                     qt_wr_sel,
   input  logic [K_W-1:0]           qt_wr_addr,
   input  logic [Q_W-1:0]           qt_wr_data,
   output logic                     qt_err,
   input  logic                     blk_start,
   input  logic                     blk_table,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [COEF_W-1:0] in_data,
   input  logic                     in_eob,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [K_W-1:0]           out_addr,
   output logic                     out_last,
   output logic                     busy
);

   state_e                   state_q, state_d;
   logic [K_W-1:0]           k_q, k_d;
   logic                     tsel_q, tsel_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]  out_data_q, out_data_d;
   logic [K_W-1:0]           out_addr_q, out_addr_d;
   logic                     out_last_q, out_last_d;
   logic                     busy_q, busy_d;
   logic                     qt_err_q, qt_err_d;

   logic [Q_W-1:0]           q_c;
   logic signed [PROD_W-1:0] prod_c;
   logic                     drop_c, out_free_c, pend_last_c, accept_c, last_k_c;

   assign drop_c      = qt_wr_en && busy_q && (qt_wr_sel == tsel_q);
   assign out_free_c  = !out_valid_q || out_ready;
   assign pend_last_c = out_valid_q && out_last_q;
   assign in_ready    = (state_q == ST_RUN) && out_free_c && !pend_last_c;
   assign accept_c    = in_valid && in_ready;
   assign last_k_c    = (k_q == K_W'(NUM_COEF - 1));
   assign prod_c      = PROD_W'(in_data) * PROD_W'($signed({1'b0, q_c}));

   dequant_qtab u_qtab (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (qt_wr_en && !drop_c),
      .wr_sel    (qt_wr_sel),
      .wr_addr   (qt_wr_addr),
      .wr_data   (qt_wr_data),
      .rd_sel    (tsel_q),
      .rd_addr   (k_q),
      .rd_data_c (q_c)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      tsel_d      = tsel_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      qt_err_d    = drop_c;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (blk_start) begin
               state_d = ST_RUN;
               k_d     = '0;
               tsel_d  = blk_table;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            // Once the 64th entry is loaded, wait only for its handshake.
            if (pend_last_c) begin
               if (out_ready) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end else if (accept_c) begin
               out_valid_d = 1'b1;
               out_data_d  = sat(prod_c);
               out_addr_d  = ZZ[k_q];
               out_last_d  = last_k_c;
               k_d         = k_q + K_W'(1);
               if (in_eob && !last_k_c) state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (pend_last_c) begin
               if (out_ready) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end else if (out_free_c) begin
               out_valid_d = 1'b1;
               out_data_d  = '0;
               out_addr_d  = ZZ[k_q];
               out_last_d  = last_k_c;
               k_d         = k_q + K_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         tsel_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         qt_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         tsel_q      <= tsel_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         qt_err_q    <= qt_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign qt_err    = qt_err_q;

endmodule

// File: tb/tb_dequant_ctrl.sv
// Directed bench for dequant_ctrl: output handshakes are logged by a monitor
// and each scenario compares the log against hand-computed values.
module tb_dequant_ctrl;
   import dequant_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     qt_wr_en, qt_wr_sel;
   logic [K_W-1:0]           qt_wr_addr;
   logic [Q_W-1:0]           qt_wr_data;
   logic                     qt_err;
   logic                     blk_start, blk_table;
   logic                     in_valid, in_ready, in_eob;
   logic signed [COEF_W-1:0] in_data;
   logic                     out_valid, out_ready, out_last, busy;
   logic signed [OUT_W-1:0]  out_data;
   logic [K_W-1:0]           out_addr;

   int errors = 0;
   int checks = 0;
   int zz_tb [64];

   logic signed [OUT_W-1:0]  mq_data [$];
   logic [K_W-1:0]           mq_addr [$];
   logic                     mq_last [$];

   always #5 clk = ~clk;

   dequant_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .qt_wr_en   (qt_wr_en),
      .qt_wr_sel  (qt_wr_sel),
      .qt_wr_addr (qt_wr_addr),
      .qt_wr_data (qt_wr_data),
      .qt_err     (qt_err),
      .blk_start  (blk_start),
      .blk_table  (blk_table),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_eob     (in_eob),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .out_last   (out_last),
      .busy       (busy)
   );

   // Outputs are stable across the low phase, so negedge sees the handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         mq_data.push_back(out_data);
         mq_addr.push_back(out_addr);
         mq_last.push_back(out_last);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic qt_write(input logic sel, input int a, input int d);
      qt_wr_en   = 1'b1;
      qt_wr_sel  = sel;
      qt_wr_addr = K_W'(a);
      qt_wr_data = Q_W'(d);
      tick();
      qt_wr_en   = 1'b0;
   endtask

   task automatic start_block(input logic tbl);
      blk_start = 1'b1;
      blk_table = tbl;
      tick();
      blk_start = 1'b0;
   endtask

   task automatic send_beat(input int d, input logic eob);
      int n = 0;
      in_valid = 1'b1;
      in_data  = COEF_W'(d);
      in_eob   = eob;
      #1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL beat_accept: in_ready stayed %b, want 1 within 50 cycles", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_eob   = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_drop: busy=%b, want 0 within 300 cycles", busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; qt_wr_en = 1'b0; qt_wr_sel = 1'b0; qt_wr_addr = '0; qt_wr_data = '0;
      blk_start = 1'b0; blk_table = 1'b0; in_valid = 1'b1; in_data = '0; in_eob = 1'b0;
      out_ready = 1'b1;
      #12;
      checks++;
      if ({in_ready, out_valid, out_last, busy, qt_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got rdy/vld/last/busy/err=%b want 00000",
                  {in_ready, out_valid, out_last, busy, qt_err});
      end
      checks++;
      if (out_data !== 16'sd0 || out_addr !== 6'd0) begin
         errors++;
         $display("FAIL reset_data: got data=%0d addr=%0d want 0/0", out_data, out_addr);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_in_ready: got %b want 0", in_ready);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_identity();
      int base = mq_data.size();
      start_block(1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise: got %b want 1", busy);
      end
      for (int k = 0; k < 64; k++) send_beat(k - 32, 1'b0);
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 64) begin
         errors++;
         $display("FAIL ident_count: got %0d want %0d", mq_data.size() - base, 64);
      end else begin
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (mq_data[base+i] !== 16'(i - 32) || mq_addr[base+i] !== 6'(zz_tb[i]) ||
                mq_last[base+i] !== (i == 63)) begin
               errors++;
               $display("FAIL ident[%0d]: got d=%0d a=%0d l=%b want d=%0d a=%0d l=%b", i,
                        mq_data[base+i], mq_addr[base+i], mq_last[base+i], i - 32, zz_tb[i], i == 63);
            end
         end
      end
   endtask

   task automatic test_eob_fill();
      int base;
      int exp_d;
      qt_write(1'b0, 0, 16);
      qt_write(1'b0, 1, 11);
      base = mq_data.size();
      start_block(1'b0);
      send_beat(-5, 1'b0);
      send_beat(3, 1'b1);
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 64) begin
         errors++;
         $display("FAIL fill_count: got %0d want %0d", mq_data.size() - base, 64);
      end else begin
         for (int i = 0; i < 64; i++) begin
            exp_d = (i == 0) ? -80 : (i == 1) ? 33 : 0;
            checks++;
            if (mq_data[base+i] !== 16'(exp_d) || mq_addr[base+i] !== 6'(zz_tb[i]) ||
                mq_last[base+i] !== (i == 63)) begin
               errors++;
               $display("FAIL fill[%0d]: got d=%0d a=%0d l=%b want d=%0d a=%0d l=%b", i,
                        mq_data[base+i], mq_addr[base+i], mq_last[base+i], exp_d, zz_tb[i], i == 63);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int base;
      qt_write(1'b0, 0, 255);
      checks++;
      if (qt_err !== 1'b0) begin
         errors++;
         $display("FAIL idle_write_err: got %b want 0", qt_err);
      end
      base = mq_data.size();
      start_block(1'b0);
      send_beat(2047, 1'b1);
      wait_idle();
      start_block(1'b0);
      send_beat(-2048, 1'b1);
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 128 || mq_data[base] !== 16'sh7fff) begin
         errors++;
         $display("FAIL sat_pos: got %0d want 32767", mq_data[base]);
      end
      checks++;
      if (mq_data.size() !== base + 128 || mq_data[base+64] !== 16'sh8000 || mq_last[base+127] !== 1'b1) begin
         errors++;
         $display("FAIL sat_neg: got %0d last=%b want -32768 last=1", mq_data[base+64], mq_last[base+127]);
      end
   endtask

   task automatic test_backpressure();
      int base = mq_data.size();
      int exp_d;
      start_block(1'b1);
      for (int k = 0; k < 5; k++) send_beat(100 + k, 1'b0);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'sd104 || out_addr !== 6'(zz_tb[4]) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_stall[%0d]: got v=%b d=%0d a=%0d rdy=%b want v=1 d=104 a=%0d rdy=0",
                     c, out_valid, out_data, out_addr, in_ready, zz_tb[4]);
         end
      end
      out_ready = 1'b1;
      for (int k = 5; k < 10; k++) send_beat(100 + k, k == 9);
      tick(); tick(); tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'sd0 || out_addr !== 6'(zz_tb[12]) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_stall[%0d]: got v=%b d=%0d a=%0d rdy=%b want v=1 d=0 a=%0d rdy=0",
                     c, out_valid, out_data, out_addr, in_ready, zz_tb[12]);
         end
      end
      out_ready = 1'b1;
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 64) begin
         errors++;
         $display("FAIL bp_count: got %0d want %0d", mq_data.size() - base, 64);
      end else begin
         for (int i = 0; i < 64; i++) begin
            exp_d = (i < 10) ? 100 + i : 0;
            checks++;
            if (mq_data[base+i] !== 16'(exp_d) || mq_addr[base+i] !== 6'(zz_tb[i]) ||
                mq_last[base+i] !== (i == 63)) begin
               errors++;
               $display("FAIL bp[%0d]: got d=%0d a=%0d l=%b want d=%0d a=%0d l=%b", i,
                        mq_data[base+i], mq_addr[base+i], mq_last[base+i], exp_d, zz_tb[i], i == 63);
            end
         end
      end
   endtask

   task automatic test_qt_err();
      int base = mq_data.size();
      start_block(1'b0);
      qt_write(1'b0, 5, 77);
      checks++;
      if (qt_err !== 1'b1) begin
         errors++;
         $display("FAIL qt_err_pulse: got %b want 1", qt_err);
      end
      qt_write(1'b1, 5, 77);
      checks++;
      if (qt_err !== 1'b0) begin
         errors++;
         $display("FAIL qt_other_table: got %b want 0", qt_err);
      end
      start_block(1'b1);
      for (int k = 0; k < 5; k++) send_beat(0, 1'b0);
      send_beat(3, 1'b1);
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 64 || mq_data[base+5] !== 16'sd3 || mq_addr[base+5] !== 6'd2) begin
         errors++;
         $display("FAIL luma_kept: got d=%0d a=%0d want d=3 a=2", mq_data[base+5], mq_addr[base+5]);
      end
      start_block(1'b1);
      for (int k = 0; k < 5; k++) send_beat(0, 1'b0);
      send_beat(3, 1'b1);
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 128 || mq_data[base+69] !== 16'sd231) begin
         errors++;
         $display("FAIL chroma_written: got %0d want 231", mq_data[base+69]);
      end
   endtask

   task automatic test_midblock_reset();
      int base = mq_data.size();
      start_block(1'b0);
      for (int k = 0; k < 30; k++) send_beat(7, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_last, busy, qt_err} !== 5'b0 || out_data !== 16'sd0 || out_addr !== 6'd0) begin
         errors++;
         $display("FAIL midreset_out: got rdy/vld/last/busy/err=%b d=%0d a=%0d want 00000 0 0",
                  {in_ready, out_valid, out_last, busy, qt_err}, out_data, out_addr);
      end
      checks++;
      if (mq_data.size() !== base + 29 || mq_last[mq_last.size()-1] !== 1'b0) begin
         errors++;
         $display("FAIL partial_block: got %0d outputs want 29 without last", mq_data.size() - base);
      end
      #3 rst_n = 1'b1;
      tick();
      base = mq_data.size();
      start_block(1'b0);
      for (int k = 0; k < 64; k++) send_beat(5, 1'b0);
      wait_idle();
      checks++;
      if (mq_data.size() !== base + 64) begin
         errors++;
         $display("FAIL post_reset_count: got %0d want 64", mq_data.size() - base);
      end else begin
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (mq_data[base+i] !== 16'sd5 || mq_addr[base+i] !== 6'(zz_tb[i]) || mq_last[base+i] !== (i == 63)) begin
               errors++;
               $display("FAIL post_reset[%0d]: got d=%0d a=%0d l=%b want d=5 a=%0d l=%b", i,
                        mq_data[base+i], mq_addr[base+i], mq_last[base+i], zz_tb[i], i == 63);
            end
         end
      end
   endtask

   initial begin
      int n = 0;
      // Derive the zigzag order by walking the anti-diagonals.
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int r = (s < 8) ? s : 7; r >= ((s > 7) ? s - 7 : 0); r--) begin
               zz_tb[n] = r * 8 + (s - r);
               n++;
            end
         end else begin
            for (int r = (s > 7) ? s - 7 : 0; r <= ((s < 8) ? s : 7); r++) begin
               zz_tb[n] = r * 8 + (s - r);
               n++;
            end
         end
      end
      test_reset();
      test_identity();
      test_eob_fill();
      test_saturation();
      test_backpressure();
      test_qt_err();
      test_midblock_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dequant_ctrl.md
# dequant_ctrl

Sequencer for the dequantization stage of the MJPEG decoder. Owns the two 64-entry quantization tables (luma/chroma), accepts one 8x8 block of zigzag-ordered coefficients from the entropy decoder, multiplies each coefficient by its table entry, and hands results to the IDCT block buffer with natural (row-major) addresses. It also zero-fills the tail of a block after an end-of-block marker, so the IDCT always receives exactly 64 writes.

## Interface

- COEF_W, 12, signed coefficient width from the entropy decoder
- Q_W, 8, unsigned quantization table entry width
- OUT_W, 16, signed dequantized output width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- qt_wr_en  in  1  quant table write strobe
- qt_wr_sel  in  1  table select for the write: 0 luma, 1 chroma
- qt_wr_addr  in  6  zigzag index of the written entry
- qt_wr_data  in  Q_W  table entry value
- qt_err  out  1  one-cycle pulse: write to the table in use was dropped
- blk_start  in  1  start a block; sampled only in IDLE
- blk_table  in  1  table used for this block, captured with blk_start
- in_valid  in  1  coefficient valid
- in_ready  out  1  coefficient accepted when in_valid && in_ready
- in_data  in  COEF_W  signed coefficient, zigzag order
- in_eob  in  1  marks this beat as the last nonzero coefficient of the block
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  OUT_W  signed dequantized coefficient
- out_addr  out  6  natural-order address (row*8+col)
- out_last  out  1  high on the 64th result of the block
- busy  out  1  high from the cycle after blk_start until the last output handshake

## Operation

- States: IDLE, RUN, FILL. Zigzag index counter k (6 bit), captured table select tsel.
- IDLE: blk_start=1 -> RUN, k=0, tsel=blk_table. blk_start is ignored outside IDLE.
- RUN: in_ready = !out_valid || out_ready. An accepted beat loads the output register: out_data = sat(in_data * Q[tsel][k]), out_addr = ZZ[k], out_last = (k==63). Then k increments.
  - If in_eob is set and k<63, go to FILL.
  - If k==63 (with or without in_eob), go to IDLE after the out_last handshake. No further beats are accepted.
- FILL: in_ready=0. Each cycle the output register is free, it loads out_data=0, out_addr=ZZ[k], out_last=(k==63), and k increments. After the k==63 entry is handshaken, go to IDLE.
- Arithmetic: the signed COEF_W × unsigned Q_W product is COEF_W+Q_W+1 bits signed. It saturates to the OUT_W range [-32768, 32767]. A table entry of 0 gives 0.
- Table writes are accepted in any state, except a write with qt_wr_sel==tsel while busy. That write is dropped and qt_err pulses for one cycle.
- Output register holds its value while out_valid && !out_ready.

## Timing

- Latency 1: a beat accepted at edge t appears on out_* after edge t. Sustained throughput is 1 per cycle when out_ready=1.
- A blk_start sampled at edge t raises busy and enters RUN after t. in_ready can be high in the cycle after t.
- A table write at edge t is visible to a multiply at edge t+1 or later. A simultaneous write and read of the same entry uses the old value.
- busy falls and the state returns to IDLE on the edge that completes the out_last handshake. A blk_start is accepted from the following edge onward.
- Reset (asynchronous, at any time including mid-block) returns to:
  - state IDLE, k=0, tsel=0
  - in_ready=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, qt_err=0
  - all table entries = 1
- The partial block in progress is discarded. No out_last is produced for it.

## Structure

- Package dequant_pkg holds:
  - the COEF_W/Q_W/OUT_W defaults
  - the state enum
  - the 64-entry zigzag-to-natural constant ZZ (ZZ[0]=0, ZZ[1]=1, ZZ[2]=8, ZZ[3]=16, ZZ[4]=9, …, ZZ[63]=63)
  - the saturate function
- One sub-module: dequant_qtab, a two-table 64×Q_W register file with one write port and one read port, reset to 1.

## Test plan

- Reset then a block with no table writes: 64 beats in_data=k-32, in_eob=0, out_ready=1 -> outputs equal k-32 (tables all 1). Address order follows ZZ. out_last only on beat 64 (addr 63). busy drops after it.
- Write luma entry 0 = 16 and entry 1 = 11, then a block with blk_table=0: in_data=-5 (k=0), 3 (k=1, in_eob=1) -> -80@addr0 and 33@addr1, then 62 zero writes at ZZ[2..63], out_last at addr 63.
- Saturation: entry 0 = 255, in_data=2047 -> 32767. in_data=-2048 -> -32768.
- Backpressure: hold out_ready=0 for 5 cycles mid-block -> out_* stable, in_ready=0, no lost or duplicated beat. Same check during FILL.
- A qt write to the active table while busy -> qt_err pulses and the value is unchanged. A write to the other table is accepted. A blk_start during RUN is ignored.
- Assert rst_n low at k=30 -> all outputs are at their reset values within the same cycle. A new block afterwards starts at addr 0 with tables at 1.
